// File: rtl/schmidl_cox_periodic_framer_if.sv
// Sample stream bundle for the Schmidl-Cox framer:
// input side (i_*) and output side (o_*) in one handshake interface.
interface schmidl_cox_periodic_framer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_tdata;
  logic             i_ttrig;
  logic             i_tvalid;
  logic             i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready;

  modport master (
    output i_tdata, i_ttrig, i_tvalid,
    input  i_tready,
    input  o_tdata, o_tlast, o_tvalid,
    output o_tready
  );

  modport slave (
    input  i_tdata, i_ttrig, i_tvalid,
    output i_tready,
    output o_tdata, o_tlast, o_tvalid,
    input  o_tready
  );
endinterface

// File: rtl/schmidl_cox_periodic_framer.sv
// Trigger-aligned offset/gap/frame slicer behind the Schmidl-Cox detector.
// Define SCHMIDL_COX_FRAMER_EOB_EN to add o_eob on the final tlast of a burst.
module schmidl_cox_periodic_framer #(
  parameter logic [7:0] SR_BASE = 8'h10,
  parameter int         WIDTH   = 32,
  parameter int         CNT_W   = 16
) (
  input  logic        ce_clk,
  input  logic        ce_rst_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  schmidl_cox_periodic_framer_if.slave strm,
  output logic        busy
`ifdef SCHMIDL_COX_FRAMER_EOB_EN
  ,
  output logic        o_eob
`endif
);

  typedef enum logic [1:0] {
    IDLE, OFFSET, GAP, FRAME
  } state_e;

  localparam logic [CNT_W-1:0] ONE = 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] wlen_q, wlen_d;
  logic [CNT_W-1:0] wgap_q, wgap_d;
  logic [CNT_W-1:0] wmax_q, wmax_d;
  logic [CNT_W-1:0] woff_q, woff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;

  logic             in_frame;
  logic             beat;
  logic             trig;
  logic             last_beat;
  logic             final_frm;
  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] fcnt_inc;

  assign in_frame  = state_q == FRAME;
  assign beat      = strm.i_tvalid & strm.i_tready;
  assign trig      = beat & strm.i_ttrig & ~in_frame;
  assign len_eff   = (wlen_q == '0) ? ONE : wlen_q;
  assign last_beat = cnt_q == len_eff - ONE;
  assign fcnt_inc  = fcnt_q + ONE;
  assign final_frm = (wmax_q != '0) && (fcnt_inc == wmax_q);

  assign strm.o_tdata  = strm.i_tdata;
  assign strm.o_tvalid = in_frame & strm.i_tvalid;
  assign strm.i_tready = in_frame ? strm.o_tready : 1'b1;
  assign strm.o_tlast  = in_frame & last_beat;
  assign busy          = state_q != IDLE;

`ifdef SCHMIDL_COX_FRAMER_EOB_EN
  assign o_eob = strm.o_tlast & final_frm;
`endif

  always_comb begin
    len_d = len_q;
    gap_d = gap_q;
    off_d = off_q;
    max_d = max_q;
    if (set_stb) begin
      case (set_addr)
        SR_BASE:         len_d = set_data[CNT_W-1:0];
        SR_BASE + 8'd1:  gap_d = set_data[CNT_W-1:0];
        SR_BASE + 8'd2:  off_d = set_data[CNT_W-1:0];
        SR_BASE + 8'd3:  max_d = set_data[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    wlen_d  = wlen_q;
    wgap_d  = wgap_q;
    woff_d  = woff_q;
    wmax_d  = wmax_q;
    if (trig) begin
      // Trigger sample is dropped; fresh settings own the new burst.
      wlen_d = len_q;
      wgap_d = gap_q;
      woff_d = off_q;
      wmax_d = max_q;
      cnt_d  = '0;
      fcnt_d = '0;
      if (off_q != '0)      state_d = OFFSET;
      else if (gap_q != '0) state_d = GAP;
      else                  state_d = FRAME;
    end else if (beat) begin
      cnt_d = cnt_q + ONE;
      unique case (state_q)
        IDLE: cnt_d = '0;
        OFFSET: begin
          if (cnt_q == woff_q - ONE) begin
            cnt_d   = '0;
            state_d = (wgap_q == '0) ? FRAME : GAP;
          end
        end
        GAP: begin
          if (cnt_q == wgap_q - ONE) begin
            cnt_d   = '0;
            state_d = FRAME;
          end
        end
        FRAME: begin
          if (last_beat) begin
            cnt_d  = '0;
            fcnt_d = fcnt_inc;
            if (final_frm)         state_d = IDLE;
            else if (wgap_q != '0) state_d = GAP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state_q <= IDLE;
      len_q   <= CNT_W'(64);
      gap_q   <= CNT_W'(16);
      off_q   <= '0;
      max_q   <= ONE;
      wlen_q  <= CNT_W'(64);
      wgap_q  <= CNT_W'(16);
      woff_q  <= '0;
      wmax_q  <= ONE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      off_q   <= off_d;
      max_q   <= max_d;
      wlen_q  <= wlen_d;
      wgap_q  <= wgap_d;
      woff_q  <= woff_d;
      wmax_q  <= wmax_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_schmidl_cox_periodic_framer.sv
// Directed bench for schmidl_cox_periodic_framer: ramp input,
// hand-computed frame positions, stalls, retrigger and reset.
module tb_schmidl_cox_periodic_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic        busy;
`ifdef SCHMIDL_COX_FRAMER_EOB_EN
  logic        eob;
`endif

  schmidl_cox_periodic_framer_if #(.WIDTH(32)) sif ();

  schmidl_cox_periodic_framer dut (
    .ce_clk   (clk),
    .ce_rst_n (rst_n),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .strm     (sif),
    .busy     (busy)
`ifdef SCHMIDL_COX_FRAMER_EOB_EN
    ,
    .o_eob    (eob)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int oq[$];
  bit lq[$];
  bit eq[$];
  bit trg[int];
  int hs_err;

  task automatic check(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int at(int k);
    return (k >= 0 && k < oq.size()) ? oq[k] : -1;
  endfunction

  function automatic int n_last();
    int n = 0;
    foreach (lq[i]) n += lq[i];
    return n;
  endfunction

  task automatic wr(logic [7:0] a, logic [31:0] d);
    @(posedge clk); #1;
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic cfg(int len, int gap, int off, int mx);
    wr(8'h10, len);
    wr(8'h11, gap);
    wr(8'h12, off);
    wr(8'h13, mx);
  endtask

  // Push ramp samples 0..n-1; samples listed in trg carry i_ttrig.
  task automatic stream(int n, bit rnd);
    int idx = 0;
    int cyc = 0;
    bit vld;
    oq.delete(); lq.delete(); eq.delete();
    hs_err = 0;
    while (idx < n && cyc < 20000) begin
      @(posedge clk); #1;
      vld = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      sif.o_tready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      sif.i_tvalid = vld;
      sif.i_tdata  = idx;
      sif.i_ttrig  = vld && trg.exists(idx);
      @(negedge clk);
      if (sif.o_tvalid && sif.i_tready !== sif.o_tready) hs_err++;
      if (vld && !sif.o_tvalid && !sif.i_tready) hs_err++;
      if (sif.o_tvalid && sif.o_tdata !== sif.i_tdata) hs_err++;
      if (sif.o_tvalid && sif.o_tready) begin
        oq.push_back(int'(sif.o_tdata));
        lq.push_back(sif.o_tlast);
`ifdef SCHMIDL_COX_FRAMER_EOB_EN
        eq.push_back(eob);
`endif
      end
      if (vld && sif.i_tready) idx++;
      cyc++;
    end
    check("stream_done", idx, n);
    @(posedge clk); #1;
    sif.i_tvalid = 1'b0;
    sif.i_ttrig  = 1'b0;
    sif.o_tready = 1'b1;
  endtask

  // 12 frames of 64 with 16-sample gaps after a 69-sample offset.
  task automatic burst_12(string tag);
    int bad = 0;
    check({tag, "_count"}, oq.size(), 768);
    foreach (oq[k]) begin
      if (oq[k] != 86 + (k / 64) * 80 + (k % 64)) bad++;
      if (lq[k] != ((k % 64) == 63)) bad++;
    end
    check({tag, "_seq"}, bad, 0);
    check({tag, "_first"}, at(0), 86);
    check({tag, "_last"}, at(767), 1029);
    check({tag, "_nlast"}, n_last(), 12);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_hs"}, hs_err, 0);
`ifdef SCHMIDL_COX_FRAMER_EOB_EN
    bad = 0;
    foreach (eq[k]) if (eq[k] != (k == 767)) bad++;
    check({tag, "_eob"}, bad, 0);
`endif
  endtask

  initial begin
    int bad;
    sif.i_tdata  = '0;
    sif.i_ttrig  = 1'b0;
    sif.i_tvalid = 1'b0;
    sif.o_tready = 1'b1;
    #12;
    rst_n = 1'b1;

    // Reset state with a valid sample presented in IDLE.
    @(posedge clk); #1;
    sif.i_tvalid = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ovalid", sif.o_tvalid, 0);
    check("rst_olast", sif.o_tlast, 0);
    check("rst_iready", sif.i_tready, 1);
    sif.i_tvalid = 1'b0;

    // Defaults 64/16/0/1.
    trg.delete(); trg[0] = 1'b1;
    stream(201, 1'b0);
    check("def_count", oq.size(), 64);
    check("def_first", at(0), 17);
    check("def_last", at(63), 80);
    check("def_tlast", lq.size() == 64 ? lq[63] : 0, 1);
    check("def_nlast", n_last(), 1);
    check("def_busy", busy, 0);
    check("def_hs", hs_err, 0);

    cfg(64, 16, 69, 12);
    stream(1101, 1'b0);
    burst_12("b12");

    stream(1101, 1'b1);
    burst_12("b12r");

    // Retrigger in GAP at 3; trigger at 10 lands inside FRAME.
    cfg(8, 4, 0, 1);
    trg.delete(); trg[0] = 1'b1; trg[3] = 1'b1; trg[10] = 1'b1;
    stream(30, 1'b0);
    check("rtg_count", oq.size(), 8);
    check("rtg_first", at(0), 8);
    check("rtg_last", at(7), 15);
    check("rtg_nlast", n_last(), 1);
    check("rtg_tlast", lq.size() == 8 ? lq[7] : 0, 1);

    // frame_len 0 behaves as 1-sample frames.
    cfg(0, 0, 0, 2);
    trg.delete(); trg[0] = 1'b1;
    stream(10, 1'b0);
    check("len0_count", oq.size(), 2);
    check("len0_vals", at(0) * 100 + at(1), 102);
    check("len0_nlast", n_last(), 2);
    check("len0_busy", busy, 0);

    // Unlimited 4-sample frames back to back.
    cfg(4, 0, 0, 0);
    stream(41, 1'b0);
    bad = 0;
    foreach (oq[k]) begin
      if (oq[k] != k + 1) bad++;
      if (lq[k] != ((k % 4) == 3)) bad++;
    end
    check("inf_count", oq.size(), 40);
    check("inf_seq", bad, 0);
    check("inf_busy", busy, 1);

    // Async reset in the middle of a frame.
    @(posedge clk); #1;
    sif.i_tvalid = 1'b1;
    sif.i_tdata  = 32'd41;
    @(posedge clk); #1;
    sif.i_tdata  = 32'd42;
    @(negedge clk);
    check("mid_ovalid", sif.o_tvalid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_ovalid", sif.o_tvalid, 0);
    check("arst_olast", sif.o_tlast, 0);
    check("arst_busy", busy, 0);
    check("arst_iready", sif.i_tready, 1);
    sif.i_tvalid = 1'b0;
    #10;
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/schmidl_cox_periodic_framer.md
Name: schmidl_cox_periodic_framer

Overview:
- Streaming framer that sits behind the Schmidl-Cox timing detector in the OFDM receive chain.
- Waits for a trigger-tagged sample, skips a programmable time offset, then repeatedly drops a cyclic prefix (gap) and forwards one FFT-sized frame with tlast, for a programmable number of frames.
- Configured through the standard settings bus (registers 0x10..0x13).
- Zero-latency pass-through datapath.

Parameters:
- SR_BASE, 8'h10, settings address of frame_len; gap_len, offset and max_frames follow at +1, +2, +3.
- WIDTH, 32, sample width ({I[31:16], Q[15:0]}).
- CNT_W, 16, counter/register width; set_data bits above CNT_W are ignored.

Ports:
- ce_clk  in  1  clock.
- ce_rst_n  in  1  reset, asynchronous, active-low.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- i_tdata  in  WIDTH  input sample.
- i_ttrig  in  1  trigger sideband, qualified by i_tvalid.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  WIDTH  output sample.
- o_tlast  out  1  last sample of a frame.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Interface: one clock, ce_clk; reset ce_rst_n is asynchronous and active-low.
- Registers and reset values:
  - SR_BASE+0 frame_len, reset 64.
  - +1 gap_len, reset 16.
  - +2 offset, reset 0.
  - +3 max_frames, reset 1.
  - Writes take effect in the next cycle. A working copy of all four is latched on each accepted trigger beat, so mid-run writes do not affect the current burst.
- Reset state: IDLE, counters 0, busy=0, o_tvalid=0, o_tlast=0.
- Beat: i_tvalid & i_tready.
- Datapath is combinational:
  - o_tdata = i_tdata.
  - In FRAME: o_tvalid = i_tvalid; i_tready = o_tready.
  - In all other states: o_tvalid = 0 and i_tready = 1 (samples discarded, never stall).
- States:
  - IDLE: discard. A beat with i_ttrig=1 latches settings; the trigger sample itself is dropped. Next state is OFFSET; if offset==0 skip to GAP; if gap_len==0 as well, go to FRAME.
  - OFFSET: drop exactly offset beats, then go to GAP (or FRAME if gap_len==0).
  - GAP: drop exactly gap_len beats, then go to FRAME.
  - FRAME:
    - Forward exactly frame_len beats; o_tlast=1 on the last one.
    - On that beat, increment frame_cnt.
    - If max_frames!=0 and frame_cnt reaches max_frames, return to IDLE.
    - Otherwise go to GAP (or stay in FRAME with a new count if gap_len==0).
- Counters reset to 0 on every state entry and advance only on beats; stalls (o_tready=0) freeze everything.
- frame_len of 0 is treated as 1.
- max_frames==0 means unlimited frames until retrigger or reset.
- Retrigger:
  - A trigger beat in OFFSET or GAP restarts the sequence exactly as from IDLE: new settings latched, frame_cnt cleared.
  - i_ttrig is ignored in FRAME, so emitted frames are always complete.
- Counters are CNT_W wide and must not wrap within a programmed length; lengths up to 2^CNT_W-1 are supported.
- Reset asserted mid-frame: immediate return to IDLE. No tlast is emitted for the truncated frame.

Optional Feature:
- Macro: SCHMIDL_COX_FRAMER_EOB_EN.
- Defined: adds output o_eob (1 bit). o_eob is asserted together with o_tlast only on the final frame of a burst (frame_cnt reaching a nonzero max_frames); it is 0 otherwise and 0 in reset.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Defaults after reset (64/16/0/1): trigger on sample 0 of a ramp 0..200. Required: 16 dropped, samples 17..80 out, tlast on 80, back to IDLE (busy=0).
- Program 64/16/69/12, trigger on sample 0. Required: first frame is samples 86..149 with tlast on 149; 12 frames total, each preceded by 16 dropped samples; the 12th frame ends on sample 86+11*80+63=1029.
- Same settings with random o_tready and i_tvalid gaps. Required: identical output sequence, i_tready=o_tready only in FRAME, and no data loss.
- Retrigger during GAP with offset=0, gap=4, frame_len=8: restart from the new trigger. A trigger asserted inside FRAME is ignored and the frame completes with 8 beats.
- max_frames=0, frame_len=4, gap=0: continuous 4-sample frames with tlast every 4th beat until reset. Asserting ce_rst_n low mid-frame forces o_tvalid=0 asynchronously.
- With SCHMIDL_COX_FRAMER_EOB_EN and max_frames=3: o_eob high only on tlast of frame 3.
